// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the posted-write store buffer.
// slave is the buffer's view; master is the core/memory environment's view.
interface store_buffer_if;
    logic        cpu_wr_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        full;
    logic        empty;
    logic        overflow;

    modport slave (
        input  cpu_wr_en, cpu_addr, cpu_wr_data, mem_ack, mem_rd_data,
        output cpu_rd_data, mem_req, mem_addr, mem_wdata, mem_rd_addr,
               full, empty, overflow
    );

    modport master (
        output cpu_wr_en, cpu_addr, cpu_wr_data, mem_ack, mem_rd_data,
        input  cpu_rd_data, mem_req, mem_addr, mem_wdata, mem_rd_addr,
               full, empty, overflow
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between a never-stalling core and a req/ack data memory,
// with store-to-load forwarding from any pending entry.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             overflow_q;
    logic             is_full;
    logic             pop;
    logic             push;
    logic [PTR_W-1:0] fwd_idx;
    logic [31:0]      fwd_data;

    assign is_full = (count == FULL_CNT);
    assign pop     = bus.mem_req & bus.mem_ack;
    // A store into a full buffer still fits when the head retires this cycle.
    assign push    = bus.cpu_wr_en & (~is_full | pop);

    assign bus.mem_req     = (count != '0);
    assign bus.full        = is_full;
    assign bus.empty       = (count == '0);
    assign bus.overflow    = overflow_q;
    assign bus.mem_addr    = {addr_mem[head], 2'b00};
    assign bus.mem_wdata   = data_mem[head];
    assign bus.mem_rd_addr = bus.cpu_addr & ~32'h3;
    assign bus.cpu_rd_data = fwd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (bus.cpu_wr_en && is_full && !pop)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= bus.cpu_addr[31:2];
            data_mem[tail] <= bus.cpu_wr_data;
        end
    end

    // Walk valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_data = bus.mem_rd_data;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[fwd_idx] == bus.cpu_addr[31:2]))
                fwd_data = data_mem[fwd_idx];
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue-based reference model updated by a
// negedge monitor, directed scenarios followed by randomized traffic.
module tb_store_buffer;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   armed;
    logic ovf_m;
    ent_t exp_q[$];

    store_buffer_if sb();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / reference model: check mid-cycle, then apply the next edge's effect.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        logic        was_full;
        logic        pop_m;
        if (rst) begin
            exp_q.delete();
            ovf_m = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            chk("empty",    {31'd0, sb.empty},    {31'd0, exp_q.size() == 0});
            chk("full",     {31'd0, sb.full},     {31'd0, exp_q.size() == DEPTH});
            chk("mem_req",  {31'd0, sb.mem_req},  {31'd0, exp_q.size() != 0});
            chk("overflow", {31'd0, sb.overflow}, {31'd0, ovf_m});
            chk("mem_rd_addr", sb.mem_rd_addr, {sb.cpu_addr[31:2], 2'b00});
            exp_rd = sb.mem_rd_data;
            foreach (exp_q[i])
                if (exp_q[i].addr[31:2] == sb.cpu_addr[31:2]) exp_rd = exp_q[i].data;
            chk("cpu_rd_data", sb.cpu_rd_data, exp_rd);
            if (exp_q.size() != 0) begin
                chk("head_addr",  sb.mem_addr,  exp_q[0].addr);
                chk("head_wdata", sb.mem_wdata, exp_q[0].data);
            end
            was_full = (exp_q.size() == DEPTH);
            pop_m    = (exp_q.size() != 0) && sb.mem_ack;
            if (pop_m) begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_addr",  sb.mem_addr,  e.addr);
                chk("drain_wdata", sb.mem_wdata, e.data);
            end
            if (sb.cpu_wr_en) begin
                if (!was_full || pop_m)
                    exp_q.push_back('{addr: sb.cpu_addr & ~32'h3, data: sb.cpu_wr_data});
                else
                    ovf_m = 1'b1;
            end
        end
    end

    task automatic step(input logic r, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic ack, input logic [31:0] rdd);
        rst            = r;
        sb.cpu_wr_en   = wr;
        sb.cpu_addr    = a;
        sb.cpu_wr_data = d;
        sb.mem_ack     = ack;
        sb.mem_rd_data = rdd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, 32'h0, 32'h0, ack, $urandom);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic drain_all();
        int unsigned n;
        n = 0;
        while (!sb.empty && n < 40) begin
            idle(1'b1);
            n++;
        end
        checks++;
        if (!sb.empty) begin
            errors++;
            $display("FAIL drain_timeout: empty=%b after %0d cycles, required 1", sb.empty, n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        ovf_m  = 1'b0;
        rst    = 1'b1;
        sb.cpu_wr_en = 1'b0; sb.cpu_addr = '0; sb.cpu_wr_data = '0;
        sb.mem_ack = 1'b0;   sb.mem_rd_data = '0;
        @(posedge clk); #1;
        do_reset();
        do_reset();

        // Single store held, then acked
        step(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, drop, drain in order
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h10, 32'h5, 1'b0, 32'h0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Push and pop together at full
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'h50 + 32'(i), 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h20, 32'hAA, 1'b1, 32'h0);
        idle(1'b0);
        drain_all();

        // Forwarding: youngest match, low bits ignored, miss falls through
        step(1'b0, 1'b1, 32'h40, 32'h11, 1'b0, 32'h99);
        step(1'b0, 1'b1, 32'h40, 32'h22, 1'b0, 32'h99);
        step(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h99);
        step(1'b0, 1'b0, 32'h43, 32'h0, 1'b0, 32'h99);
        step(1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 32'h99);
        step(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h99);
        step(1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h99);
        step(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h99);

        // Reset with pending entries and overflow set
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'(i), 1'b0, 32'h0);
        idle(1'b1);
        idle(1'b0);
        do_reset();
        step(1'b0, 1'b1, 32'h80, 32'h5, 1'b0, 32'h0);
        idle(1'b0);
        drain_all();

        // Back-to-back stores with ack tied high
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, $urandom);
        drain_all();

        // Randomized traffic on a small address window to provoke forwarding hits
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                 32'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), $urandom);
        end
        drain_all();
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
